aes_stream_ctrl: RTL and testbench
==================================

AES_STREAM_CTRL -- requirements
Module: aes_stream_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 2000, giving the maximum core cycles allowed from start to done before abort.
REQ-002 The block SHALL have the following ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  request carries a key/plaintext pair.
- in_ready  out  1  block accepts the request this cycle.
- in_key  in  128  AES-128 key.
- in_pt  in  128  plaintext block.
- core_start  out  1  one-cycle start pulse to the aes_top core.
- core_key  out  128  key held to the core.
- core_pt  out  128  plaintext held to the core.
- core_busy  in  1  core busy.
- core_done  in  1  core result valid.
- core_ct  in  128  core ciphertext.
- core_fault  in  1  core fault indication.
- out_valid  out  1  output buffer head is valid.
- out_ready  in  1  consumer takes the head entry.
- out_ct  out  128  ciphertext of the head entry.
- out_err  out  1  head entry is errored (fault or timeout).
- out_latency  out  16  core latency of the head entry, in cycles.
- fault_sticky  out  1  a core fault has been seen since reset.
- timeout_sticky  out  1  a timeout has been seen since reset.
- blk_count  out  32  number of entries pushed to the output buffer.
- lat_max  out  16  largest latency recorded since reset.

Function
REQ-003 The state machine SHALL have states IDLE, LAUNCH, WAIT and DRAIN.
REQ-004 in_ready SHALL equal (state==IDLE) AND (output buffer occupancy < 2).
REQ-005 In IDLE with in_valid && in_ready, the block SHALL register in_key/in_pt into core_key/core_pt and go to LAUNCH.
- core_key/core_pt SHALL stay stable until the next accept.
REQ-006 In LAUNCH, core_start SHALL be 1 for exactly that one cycle, and the state SHALL go to WAIT.
- core_start SHALL be 0 in every other state.
REQ-007 Latency counter behaviour:
- The counter SHALL clear to 0 in LAUNCH.
- It SHALL increment by 1 on each WAIT cycle in which core_done is 0.
- Latency SHALL be (counter value + 1) at the edge where core_done is sampled 1.
REQ-008 In WAIT with core_done=1, the block SHALL push an entry {err=core_fault, latency, ct=core_ct} and return to IDLE.
REQ-009 core_fault sampled high in any WAIT cycle SHALL force err=1 on that transaction's entry and set fault_sticky.
REQ-010 Timeout handling:
- If the counter reaches TIMEOUT_CYCLES with core_done still 0, the block SHALL push {err=1, latency=TIMEOUT_CYCLES, ct=0}, set timeout_sticky and go to DRAIN.
- DRAIN SHALL go to IDLE on the first cycle core_busy is 0.
- Any core_done during DRAIN SHALL be ignored.
REQ-011 The output buffer SHALL be a 2-entry FIFO of 145 bits, and out_* SHALL present the head combinationally from its registers.
REQ-012 A pop SHALL occur when out_valid && out_ready.
- Push and pop in the same cycle SHALL both take effect; occupancy is unchanged.
- With a single transaction in flight plus the REQ-004 gating, a push SHALL never find the buffer full.
REQ-013 blk_count and lat_max counters:
- blk_count SHALL increment by 1 on every push and wrap from 2^32-1 to 0.
- lat_max SHALL update on non-timeout pushes when the new latency is greater than lat_max.
- latency SHALL saturate at 16'hFFFF.
REQ-014 in_valid while in_ready=0 SHALL not be consumed; the requester holds the data.

Reset
REQ-015 With rst=1 at a rising edge, the block SHALL enter IDLE and reset:
- The buffer SHALL be empty.
- in_ready=0 that cycle, then 1 after reset release.
- core_start=0, core_key=0, core_pt=0.
- out_valid=0, out_ct=0, out_err=0, out_latency=0.
- fault_sticky=0, timeout_sticky=0, blk_count=0, lat_max=0.
REQ-016 Reset in LAUNCH/WAIT/DRAIN SHALL abandon the transaction without pushing an entry.

Verification
REQ-017 The bench SHALL cover these scenarios:
- FIPS-197 vector: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, core model raising done 11 cycles after start -> out_ct 69c4e0d86a7b0430d8cdb78070b4c55a, out_err 0, out_latency 11, blk_count 1, lat_max 11.
- Backpressure: out_ready=0, three requests offered back-to-back -> two entries buffered, in_ready stays 0, third request held; one pop -> third accepted; entry order preserved.
- Timeout: TIMEOUT_CYCLES=20, core never raises done, busy high 30 cycles -> entry {err 1, latency 20, ct 0}, timeout_sticky 1, in_ready 0 until core_busy falls.
- Fault: core_fault pulsed mid-WAIT, done with a valid ct -> entry err 1 with that ct, fault_sticky 1; the next clean transaction gives err 0.
- Simultaneous push/pop at occupancy 1 -> occupancy remains 1, no entry lost or duplicated.
- Reset asserted in WAIT -> next cycle out_valid 0, core_start 0, counters and flags 0; a late core_done produces no entry.

Source files
------------

// File: rtl/aes_stream_ctrl.sv
// Stream controller for an AES-128 core: accepts key/plaintext requests, launches the core,
// times the result (with timeout abort) and queues {err, latency, ct} in a 2-entry output buffer.
module aes_stream_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 2000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_key,
  input  logic [127:0] in_pt,
  output logic         core_start,
  output logic [127:0] core_key,
  output logic [127:0] core_pt,
  input  logic         core_busy,
  input  logic         core_done,
  input  logic [127:0] core_ct,
  input  logic         core_fault,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_ct,
  output logic         out_err,
  output logic [15:0]  out_latency,
  output logic         fault_sticky,
  output logic         timeout_sticky,
  output logic [31:0]  blk_count,
  output logic [15:0]  lat_max
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DRAIN} state_t;

  typedef struct packed {
    logic         err;
    logic [15:0]  latency;
    logic [127:0] ct;
  } entry_t;

  localparam logic [31:0] TIMEOUT_W   = 32'(TIMEOUT_CYCLES);
  localparam logic [15:0] TIMEOUT_LAT = (TIMEOUT_CYCLES > 65535) ? 16'hFFFF : 16'(TIMEOUT_CYCLES);

  state_t      state, state_nxt;
  logic [31:0] lat_cnt;
  logic [31:0] lat_inc;
  logic [15:0] lat_sat;
  logic        txn_fault;
  logic        accept, push, pop, timeout_hit;
  entry_t      push_entry;
  entry_t      buf_q [2];
  entry_t      head;
  logic        wr_ptr, rd_ptr;
  logic [1:0]  occ;

  assign lat_inc     = lat_cnt + 32'd1;
  assign lat_sat     = (lat_inc > 32'h0000_FFFF) ? 16'hFFFF : lat_inc[15:0];
  // The counter would reach the limit on this edge with no result yet.
  assign timeout_hit = (state == WAIT) && !core_done && (lat_inc >= TIMEOUT_W);
  assign accept      = in_valid && in_ready;
  assign pop         = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT:    if (core_done) state_nxt = IDLE;
               else if (timeout_hit) state_nxt = DRAIN;
      DRAIN:   if (!core_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = !rst && (state == IDLE) && (occ < 2'd2);
    core_start = (state == LAUNCH);
    push       = 1'b0;
    push_entry = '0;
    if (state == WAIT) begin
      if (core_done) begin
        push               = 1'b1;
        push_entry.err     = core_fault || txn_fault;
        push_entry.latency = lat_sat;
        push_entry.ct      = core_ct;
      end else if (timeout_hit) begin
        push               = 1'b1;
        push_entry.err     = 1'b1;
        push_entry.latency = TIMEOUT_LAT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      core_key       <= '0;
      core_pt        <= '0;
      lat_cnt        <= '0;
      txn_fault      <= 1'b0;
      fault_sticky   <= 1'b0;
      timeout_sticky <= 1'b0;
      blk_count      <= '0;
      lat_max        <= '0;
    end else begin
      if (accept) begin
        core_key <= in_key;
        core_pt  <= in_pt;
      end
      if (state == LAUNCH) begin
        lat_cnt   <= '0;
        txn_fault <= 1'b0;
      end else if (state == WAIT && !core_done) begin
        lat_cnt <= lat_inc;
      end
      if (state == WAIT && core_fault) begin
        txn_fault    <= 1'b1;
        fault_sticky <= 1'b1;
      end
      if (timeout_hit) timeout_sticky <= 1'b1;
      if (push) blk_count <= blk_count + 32'd1;
      // Timeout entries carry a synthetic latency and are kept out of the maximum.
      if (push && core_done && (lat_sat > lat_max)) lat_max <= lat_sat;
    end
  end

  // NOTE: buffer entries are reset because out_* expose the head register directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ      <= '0;
    end else begin
      if (push) begin
        buf_q[wr_ptr] <= push_entry;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign head        = buf_q[rd_ptr];
  assign out_valid   = (occ != 2'd0);
  assign out_ct      = head.ct;
  assign out_err     = head.err;
  assign out_latency = head.latency;

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Bench for aes_stream_ctrl: behavioural AES-core stub plus a queue scoreboard that
// predicts each output entry from the request timing rules; directed then random traffic.
module tb_aes_stream_ctrl;

  localparam int TO = 20;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct packed {
    logic         err;
    logic [15:0]  lat;
    logic [127:0] ct;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_key = '0;
  logic [127:0] in_pt = '0;
  logic         core_start;
  logic [127:0] core_key, core_pt;
  logic         core_busy = 1'b0;
  logic         core_done = 1'b0;
  logic [127:0] core_ct = '0;
  logic         core_fault = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_ct;
  logic         out_err;
  logic [15:0]  out_latency;
  logic         fault_sticky, timeout_sticky;
  logic [31:0]  blk_count;
  logic [15:0]  lat_max;

  always #5 clk = ~clk;

  aes_stream_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_pt(in_pt),
    .core_start(core_start), .core_key(core_key), .core_pt(core_pt),
    .core_busy(core_busy), .core_done(core_done), .core_ct(core_ct), .core_fault(core_fault),
    .out_valid(out_valid), .out_ready(out_ready), .out_ct(out_ct), .out_err(out_err),
    .out_latency(out_latency), .fault_sticky(fault_sticky), .timeout_sticky(timeout_sticky),
    .blk_count(blk_count), .lat_max(lat_max)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stub core "cipher": the real answer for the FIPS-197 vector, a fixed mix otherwise.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return k ^ {p[63:0], p[127:64]} ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
  endfunction

  // Core configuration for the next launch; delay 0 means the core never reports done.
  int cfg_delay = 1, cfg_busy_len = 1, cfg_fault_at = 0;

  // Reference model state.
  ent_t        exp_q[$];
  int          exp_blk = 0;
  logic [15:0] exp_lat_max = '0;
  bit          exp_fault = 1'b0, exp_timeout = 1'b0;

  bit           m_active = 1'b0;
  int           m_k = 0, m_delay = 0, m_busy_len = 0, m_fault_at = 0;
  logic [127:0] m_ct = '0;
  int           starts = 0;

  // Core stub: the cycle holding core_start is k=0, done is driven in cycle k=delay.
  always @(negedge clk) begin
    if (core_start) starts++;
    if (m_active) begin
      m_k++;
      core_done  = (m_delay != 0) && (m_k == m_delay);
      core_fault = (m_fault_at != 0) && (m_k == m_fault_at);
      core_ct    = core_done ? m_ct : '0;
      core_busy  = (m_k < m_busy_len);
      if (m_k >= m_busy_len && m_k >= m_delay) m_active = 1'b0;
    end else begin
      core_done  = 1'b0;
      core_fault = 1'b0;
      core_ct    = '0;
      core_busy  = 1'b0;
      if (core_start) begin
        ent_t e;
        m_active   = 1'b1;
        m_k        = 0;
        m_delay    = cfg_delay;
        m_busy_len = cfg_busy_len;
        m_fault_at = cfg_fault_at;
        m_ct       = core_fn(core_key, core_pt);
        core_busy  = 1'b1;
        if (m_delay != 0 && m_delay <= TO) begin
          e.err = (m_fault_at >= 1 && m_fault_at <= m_delay);
          e.lat = 16'(m_delay);
          e.ct  = m_ct;
          if (e.err) exp_fault = 1'b1;
          if (e.lat > exp_lat_max) exp_lat_max = e.lat;
        end else begin
          e.err = 1'b1;
          e.lat = 16'(TO);
          e.ct  = '0;
          exp_timeout = 1'b1;
        end
        exp_q.push_back(e);
        exp_blk++;
      end
    end
  end

  // Consumer: optionally randomizes out_ready, and checks every popped entry in order.
  bit rand_ready = 1'b0;
  always @(negedge clk) begin
    if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_entry", 128'(out_valid), 128'(0));
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        check("pop_ct", out_ct, e.ct);
        check("pop_err", 128'(out_err), 128'(e.err));
        check("pop_lat", 128'(out_latency), 128'(e.lat));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offer one request and hold it until accepted or the budget runs out.
  task automatic send(input logic [127:0] k, input logic [127:0] p, input int max_wait, output bit ok);
    in_valid = 1'b1;
    in_key   = k;
    in_pt    = p;
    ok       = 1'b0;
    for (int i = 0; i < max_wait && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    if (!rand_ready) out_ready = 1'b1;
    while ((exp_q.size() != 0 || m_active) && n < max_cycles) begin
      tick(1);
      n++;
    end
    if (!rand_ready) out_ready = 1'b0;
    check("drain_done", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    bit           ok;
    int           bad;
    int           r;
    logic [127:0] k, p;

    // Reset state.
    tick(1);
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_flags", 128'({out_valid, out_err, core_start, fault_sticky, timeout_sticky}), 128'(0));
    check("rst_out_ct", out_ct, 128'(0));
    check("rst_out_lat", 128'(out_latency), 128'(0));
    check("rst_core_key", core_key, 128'(0));
    check("rst_core_pt", core_pt, 128'(0));
    check("rst_counters", 128'({blk_count, lat_max}), 128'(0));
    rst = 1'b0;
    tick(1);
    check("post_rst_in_ready", 128'(in_ready), 128'(1));

    // FIPS-197 vector, done 11 cycles after start.
    cfg_delay = 11; cfg_busy_len = 11; cfg_fault_at = 0;
    send(FIPS_KEY, FIPS_PT, 50, ok);
    check("fips_accept", 128'(ok), 128'(1));
    tick(12);
    check("fips_valid", 128'(out_valid), 128'(1));
    check("fips_ct", out_ct, FIPS_CT);
    check("fips_err", 128'(out_err), 128'(0));
    check("fips_lat", 128'(out_latency), 128'd11);
    check("fips_blk_count", 128'(blk_count), 128'd1);
    check("fips_lat_max", 128'(lat_max), 128'd11);
    check("fips_core_key", core_key, FIPS_KEY);
    check("fips_core_pt", core_pt, FIPS_PT);
    check("fips_start_pulses", 128'(starts), 128'd1);
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
    check("fips_popped", 128'(out_valid), 128'(0));

    // Backpressure: two entries fill the buffer, third request is held.
    cfg_delay = 3; cfg_busy_len = 3;
    send(128'hA1, 128'hA2, 50, ok);
    check("bp_accept_a", 128'(ok), 128'(1));
    send(128'hB1, 128'hB2, 50, ok);
    check("bp_accept_b", 128'(ok), 128'(1));
    in_valid = 1'b1; in_key = 128'hC1; in_pt = 128'hC2;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (in_ready) bad++;
      tick(1);
    end
    check("bp_in_ready_held", 128'(bad), 128'(0));
    check("bp_blk_count", 128'(blk_count), 128'd3);
    check("bp_out_valid", 128'(out_valid), 128'(1));
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
    send(128'hC1, 128'hC2, 10, ok);
    check("bp_accept_c", 128'(ok), 128'(1));
    tick(5);
    check("bp_blk_count_c", 128'(blk_count), 128'd4);
    wait_drain(100);

    // Timeout: done would come at 25 (inside DRAIN), busy low at 30.
    cfg_delay = 25; cfg_busy_len = 30;
    send(128'hD1, 128'hD2, 50, ok);
    check("to_accept", 128'(ok), 128'(1));
    tick(21);
    check("to_valid", 128'(out_valid), 128'(1));
    check("to_err", 128'(out_err), 128'(1));
    check("to_lat", 128'(out_latency), 128'd20);
    check("to_ct", out_ct, 128'(0));
    check("to_sticky", 128'(timeout_sticky), 128'(1));
    check("to_lat_max", 128'(lat_max), 128'd11);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready) bad++;
      tick(1);
    end
    check("to_drain_in_ready", 128'(bad), 128'(0));
    check("to_late_done_ignored", 128'(blk_count), 128'd5);
    check("to_release", 128'(in_ready), 128'(1));
    check("to_no_fault", 128'(fault_sticky), 128'(0));
    wait_drain(100);

    // Fault mid-WAIT, then a clean transaction at the timeout boundary.
    cfg_delay = 12; cfg_busy_len = 12; cfg_fault_at = 5;
    send(128'hE1, 128'hE2, 50, ok);
    check("flt_accept", 128'(ok), 128'(1));
    tick(13);
    check("flt_err", 128'(out_err), 128'(1));
    check("flt_ct", out_ct, core_fn(128'hE1, 128'hE2));
    check("flt_lat", 128'(out_latency), 128'd12);
    check("flt_sticky", 128'(fault_sticky), 128'(1));
    wait_drain(100);
    cfg_delay = 20; cfg_busy_len = 20; cfg_fault_at = 0;
    send(128'hF1, 128'hF2, 50, ok);
    check("clean_accept", 128'(ok), 128'(1));
    tick(21);
    check("clean_err", 128'(out_err), 128'(0));
    check("clean_lat", 128'(out_latency), 128'd20);
    check("clean_ct", out_ct, core_fn(128'hF1, 128'hF2));
    check("clean_lat_max", 128'(lat_max), 128'd20);
    wait_drain(100);

    // Push and pop on the same edge at occupancy 1.
    cfg_delay = 6; cfg_busy_len = 6;
    send(128'h11, 128'h12, 50, ok);
    tick(8);
    send(128'h21, 128'h22, 50, ok);
    check("pp_accept", 128'(ok), 128'(1));
    tick(6);
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
    check("pp_valid", 128'(out_valid), 128'(1));
    check("pp_head_ct", out_ct, core_fn(128'h21, 128'h22));
    check("pp_blk_count", 128'(blk_count), 128'd9);
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
    check("pp_empty", 128'(out_valid), 128'(0));
    check("pp_scoreboard", 128'(exp_q.size()), 128'(0));

    // Random traffic with random consumer backpressure.
    rand_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      p = {$urandom(), $urandom(), $urandom(), $urandom()};
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        cfg_delay    = int'($urandom_range(21, 26));
        cfg_busy_len = int'($urandom_range(cfg_delay, 30));
        cfg_fault_at = 0;
      end else begin
        cfg_delay    = int'($urandom_range(1, 20));
        cfg_busy_len = cfg_delay;
        cfg_fault_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, cfg_delay)) : 0;
      end
      send(k, p, 300, ok);
      check("rand_accept", 128'(ok), 128'(1));
    end
    wait_drain(2000);
    rand_ready = 1'b0;
    tick(1);
    out_ready = 1'b0;
    check("rand_blk_count", 128'(blk_count), 128'(exp_blk));
    check("rand_lat_max", 128'(lat_max), 128'(exp_lat_max));
    check("rand_fault_sticky", 128'(fault_sticky), 128'(exp_fault));
    check("rand_timeout_sticky", 128'(timeout_sticky), 128'(exp_timeout));

    // Reset while in WAIT; the late done must not create an entry.
    cfg_delay = 15; cfg_busy_len = 15; cfg_fault_at = 0;
    send(128'h31, 128'h32, 50, ok);
    tick(5);
    rst = 1'b1;
    tick(1);
    check("wrst_out_valid", 128'(out_valid), 128'(0));
    check("wrst_core_start", 128'(core_start), 128'(0));
    check("wrst_flags", 128'({fault_sticky, timeout_sticky}), 128'(0));
    check("wrst_counters", 128'({blk_count, lat_max}), 128'(0));
    check("wrst_out_ct", out_ct, 128'(0));
    check("wrst_in_ready", 128'(in_ready), 128'(0));
    rst = 1'b0;
    exp_q.delete();
    exp_blk = 0; exp_lat_max = '0; exp_fault = 1'b0; exp_timeout = 1'b0;
    tick(15);
    check("wrst_no_entry", 128'(out_valid), 128'(0));
    check("wrst_blk_count", 128'(blk_count), 128'(0));
    check("wrst_in_ready_after", 128'(in_ready), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
